// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - Tuse/Tnew hazard scoreboard for a five-stage MIPS pipeline
// Shadow-tracks E/M/W destinations and result latencies plus the MD unit countdown.

module hazard_scoreboard #(
   parameter int AW          = 5,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic [AW-1:0] RS_D,
   input  logic [AW-1:0] RT_D,
   input  logic [1:0]    TUSE_RS_D,
   input  logic [1:0]    TUSE_RT_D,
   input  logic [AW-1:0] DST_D,
   input  logic [1:0]    TNEW_D,
   input  logic          MD_USE_D,
   input  logic [1:0]    MD_START_D,
   input  logic          EXC_FLUSH,
   output logic          STALL_PC,
   output logic          STALL_D,
   output logic          FLUSH_E,
   output logic [1:0]    FWD_RS_D,
   output logic [1:0]    FWD_RT_D,
   output logic [1:0]    FWD_RS_E,
   output logic [1:0]    FWD_RT_E,
   output logic          FWD_RT_M,
   output logic          MD_BUSY
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

   logic [AW-1:0] e_dst_q, e_dst_d, e_rs_q, e_rs_d, e_rt_q, e_rt_d;
   logic [1:0]    e_tnew_q, e_tnew_d, e_md_q, e_md_d;
   logic [AW-1:0] m_dst_q, m_dst_d, m_rt_q, m_rt_d;
   logic [1:0]    m_tnew_q, m_tnew_d;
   logic [AW-1:0] w_dst_q, w_dst_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          stall;
   logic          md_busy;
   logic [1:0]    md_start;

   function automatic logic src_stall(input logic [AW-1:0] s, input logic [1:0] tuse);
      logic hit_e;
      logic hit_m;
      hit_e = (e_dst_q == s) && (e_tnew_q > tuse);
      hit_m = (m_dst_q == s) && (m_tnew_q > tuse);
      return (s != '0) && (tuse != 2'd3) && (hit_e || hit_m);
   endfunction

   // Youngest ready producer wins; W is always ready by construction.
   function automatic logic [1:0] fwd_d(input logic [AW-1:0] s);
      logic [1:0] sel;
      sel = 2'd0;
      if (s != '0) begin
         if ((e_dst_q == s) && (e_tnew_q == 2'd0))      sel = 2'd1;
         else if ((m_dst_q == s) && (m_tnew_q == 2'd0)) sel = 2'd2;
         else if (w_dst_q == s)                         sel = 2'd3;
      end
      return sel;
   endfunction

   function automatic logic [1:0] fwd_e(input logic [AW-1:0] s);
      logic [1:0] sel;
      sel = 2'd0;
      if (s != '0) begin
         if ((m_dst_q == s) && (m_tnew_q == 2'd0)) sel = 2'd1;
         else if (w_dst_q == s)                    sel = 2'd2;
      end
      return sel;
   endfunction

   assign md_start = (MD_START_D == 2'b11) ? 2'b00 : MD_START_D;
   assign md_busy  = (cnt_q != '0) || (e_md_q != 2'b00);
   assign stall    = src_stall(RS_D, TUSE_RS_D) || src_stall(RT_D, TUSE_RT_D) ||
                     (MD_USE_D && md_busy);

   assign STALL_PC = stall;
   assign STALL_D  = stall;
   assign FLUSH_E  = stall;
   assign MD_BUSY  = md_busy;
   assign FWD_RS_D = fwd_d(RS_D);
   assign FWD_RT_D = fwd_d(RT_D);
   assign FWD_RS_E = fwd_e(e_rs_q);
   assign FWD_RT_E = fwd_e(e_rt_q);
   assign FWD_RT_M = (m_rt_q != '0) && (m_rt_q == w_dst_q);

   always_comb begin
      e_dst_d  = DST_D;
      e_tnew_d = TNEW_D;
      e_rs_d   = RS_D;
      e_rt_d   = RT_D;
      e_md_d   = md_start;
      if (stall || EXC_FLUSH) begin
         e_dst_d  = '0;
         e_tnew_d = 2'd0;
         e_rs_d   = '0;
         e_rt_d   = '0;
         e_md_d   = 2'b00;
      end

      m_dst_d  = e_dst_q;
      m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
      m_rt_d   = e_rt_q;
      if (EXC_FLUSH) begin
         m_dst_d  = '0;
         m_tnew_d = 2'd0;
         m_rt_d   = '0;
      end

      w_dst_d = m_dst_q;

      // A start killed in E never loads; a running count survives the flush.
      cnt_d = cnt_q;
      if ((e_md_q != 2'b00) && !EXC_FLUSH)
         cnt_d = (e_md_q == 2'b01) ? MULT_LD : DIV_LD;
      else if (cnt_q != '0)
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         e_dst_q  <= '0;
         e_tnew_q <= 2'd0;
         e_rs_q   <= '0;
         e_rt_q   <= '0;
         e_md_q   <= 2'b00;
         m_dst_q  <= '0;
         m_tnew_q <= 2'd0;
         m_rt_q   <= '0;
         w_dst_q  <= '0;
         cnt_q    <= '0;
      end else begin
         e_dst_q  <= e_dst_d;
         e_tnew_q <= e_tnew_d;
         e_rs_q   <= e_rs_d;
         e_rt_q   <= e_rt_d;
         e_md_q   <= e_md_d;
         m_dst_q  <= m_dst_d;
         m_tnew_q <= m_tnew_d;
         m_rt_q   <= m_rt_d;
         w_dst_q  <= w_dst_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
// Model keeps a per-cycle history of what entered E and derives stage contents by age.

module tb_hazard_scoreboard;

   localparam int AW   = 5;
   localparam int MC   = 5;
   localparam int DC   = 10;
   localparam int MAXN = 10;
   localparam int HN   = 4096;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic [AW-1:0] RS_D, RT_D, DST_D;
   logic [1:0]    TUSE_RS_D, TUSE_RT_D, TNEW_D, MD_START_D;
   logic          MD_USE_D, EXC_FLUSH;
   logic          STALL_PC, STALL_D, FLUSH_E, FWD_RT_M, MD_BUSY;
   logic [1:0]    FWD_RS_D, FWD_RT_D, FWD_RS_E, FWD_RT_E;

   int checks = 0;
   int failures = 0;
   int cyc = 32;
   int hd[HN], ht[HN], hrs[HN], hrt[HN], hmd[HN];
   bit hfl[HN];
   int e_stall, e_frsd, e_frtd, e_frse, e_frte, e_frtm, e_busy;
   int o_stall, o_frsd, o_frtd, o_frse, o_frte, o_frtm, o_busy;

   hazard_scoreboard #(.AW(AW), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .RS_D(RS_D), .RT_D(RT_D), .TUSE_RS_D(TUSE_RS_D), .TUSE_RT_D(TUSE_RT_D),
      .DST_D(DST_D), .TNEW_D(TNEW_D), .MD_USE_D(MD_USE_D), .MD_START_D(MD_START_D),
      .EXC_FLUSH(EXC_FLUSH),
      .STALL_PC(STALL_PC), .STALL_D(STALL_D), .FLUSH_E(FLUSH_E),
      .FWD_RS_D(FWD_RS_D), .FWD_RT_D(FWD_RT_D), .FWD_RS_E(FWD_RS_E),
      .FWD_RT_E(FWD_RT_E), .FWD_RT_M(FWD_RT_M), .MD_BUSY(MD_BUSY)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, want, cyc);
      end
   endtask

   function automatic int rem(input int tnew, input int age);
      return (tnew > age) ? tnew - age : 0;
   endfunction

   // An instruction of age a survives unless a flush hit it while it sat in E.
   function automatic bit alive(input int age);
      return (age == 0) ? 1'b1 : !hfl[cyc - age];
   endfunction

   function automatic int st_dst(input int age);
      return alive(age) ? hd[cyc - age] : 0;
   endfunction

   function automatic bit src_haz(input int s, input int tu);
      if (s == 0 || tu == 3) return 1'b0;
      for (int a = 0; a <= 1; a++)
         if (st_dst(a) == s && rem(ht[cyc - a], a) > tu) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int fwd_from(input int s, input int first_age);
      if (s == 0) return 0;
      for (int a = first_age; a <= 2; a++)
         if (st_dst(a) == s && (a == 2 || rem(ht[cyc - a], a) == 0)) return a - first_age + 1;
      return 0;
   endfunction

   function automatic int md_busy_model();
      if (hmd[cyc] != 0) return 1;
      for (int a = 1; a <= MAXN; a++)
         if (hmd[cyc - a] != 0 && !hfl[cyc - a]) return (a <= ((hmd[cyc - a] == 1) ? MC : DC)) ? 1 : 0;
      return 0;
   endfunction

   task automatic set_instr(input int rs, input int rt, input int trs, input int trt,
                            input int dst, input int tnew, input int mduse, input int mdst);
      RS_D = AW'(rs); RT_D = AW'(rt); TUSE_RS_D = 2'(trs); TUSE_RT_D = 2'(trt);
      DST_D = AW'(dst); TNEW_D = 2'(tnew); MD_USE_D = 1'(mduse); MD_START_D = 2'(mdst);
   endtask

   task automatic set_nop();
      set_instr(0, 0, 3, 3, 0, 0, 0, 0);
   endtask

   task automatic run_cycle();
      #2;
      e_busy = md_busy_model();
      e_stall = (src_haz(int'(RS_D), int'(TUSE_RS_D)) || src_haz(int'(RT_D), int'(TUSE_RT_D)) ||
                 (MD_USE_D && e_busy != 0)) ? 1 : 0;
      e_frsd = fwd_from(int'(RS_D), 0);
      e_frtd = fwd_from(int'(RT_D), 0);
      e_frse = fwd_from(hrs[cyc], 1);
      e_frte = fwd_from(hrt[cyc], 1);
      e_frtm = alive(1) ? fwd_from(hrt[cyc - 1], 2) : 0;
      o_stall = int'(STALL_D); o_frsd = int'(FWD_RS_D); o_frtd = int'(FWD_RT_D);
      o_frse = int'(FWD_RS_E); o_frte = int'(FWD_RT_E); o_frtm = int'(FWD_RT_M);
      o_busy = int'(MD_BUSY);
      chk("stall_pc", int'(STALL_PC), e_stall);
      chk("stall_d", o_stall, e_stall);
      chk("flush_e", int'(FLUSH_E), e_stall);
      chk("fwd_rs_d", o_frsd, e_frsd);
      chk("fwd_rt_d", o_frtd, e_frtd);
      chk("fwd_rs_e", o_frse, e_frse);
      chk("fwd_rt_e", o_frte, e_frte);
      chk("fwd_rt_m", o_frtm, e_frtm);
      chk("md_busy", o_busy, e_busy);
      @(posedge CLK);
      hfl[cyc] = EXC_FLUSH;
      cyc++;
      if (e_stall != 0 || EXC_FLUSH) begin
         hd[cyc] = 0; ht[cyc] = 0; hrs[cyc] = 0; hrt[cyc] = 0; hmd[cyc] = 0;
      end else begin
         hd[cyc] = int'(DST_D); ht[cyc] = int'(TNEW_D);
         hrs[cyc] = int'(RS_D); hrt[cyc] = int'(RT_D);
         hmd[cyc] = (MD_START_D == 2'b11) ? 0 : int'(MD_START_D);
      end
      #1;
   endtask

   task automatic issue(input string tag, input int exp_stalls);
      int n = 0;
      int guard = 0;
      do begin
         run_cycle();
         if (o_stall != 0) n++;
         guard++;
      end while (e_stall != 0 && guard < 40);
      chk(tag, n, exp_stalls);
   endtask

   task automatic nops(input int n);
      set_nop();
      repeat (n) run_cycle();
   endtask

   task automatic do_reset();
      set_instr(0, 0, 3, 3, 0, 1, 1, 0);
      #2;
      chk("busy_before_rst", int'(MD_BUSY), 1);
      RST_N = 1'b0;
      #1;
      chk("rst_md_busy", int'(MD_BUSY), 0);
      chk("rst_stall", int'(STALL_D), 0);
      chk("rst_fwd_e", int'(FWD_RS_E) + int'(FWD_RT_E) + int'(FWD_RT_M), 0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      cyc++;
      for (int k = cyc - 20; k <= cyc; k++) begin
         hd[k] = 0; ht[k] = 0; hrs[k] = 0; hrt[k] = 0; hmd[k] = 0; hfl[k] = 0;
      end
      e_stall = 0;
   endtask

   initial begin
      EXC_FLUSH = 1'b0;
      set_nop();
      e_stall = 0;
      repeat (2) @(posedge CLK);
      #1;
      set_instr(3, 2, 0, 0, 3, 2, 1, 1);
      #1;
      chk("reset_busy", int'(MD_BUSY), 0);
      chk("reset_stall", int'(STALL_D), 0);
      chk("reset_fwd_d", int'(FWD_RS_D) + int'(FWD_RT_D), 0);
      chk("reset_fwd_em", int'(FWD_RS_E) + int'(FWD_RT_E) + int'(FWD_RT_M), 0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      set_nop();

      set_instr(0, 0, 3, 3, 8, 2, 0, 0);  issue("lw_issue", 0);
      set_instr(8, 0, 1, 3, 9, 1, 0, 0);  issue("load_use_stalls", 1);
      set_nop(); run_cycle();
      chk("load_use_fwd_rs_e", o_frse, 2);

      nops(3);
      set_instr(0, 0, 3, 3, 9, 1, 0, 0);  issue("add_issue", 0);
      set_instr(9, 0, 0, 3, 0, 0, 0, 0);  issue("alu_branch_stalls", 1);
      chk("alu_branch_fwd_rs_d", o_frsd, 2);

      nops(3);
      set_instr(0, 0, 3, 3, 8, 2, 0, 0);  issue("lw_issue2", 0);
      set_instr(8, 0, 0, 3, 0, 0, 0, 0);  issue("load_branch_stalls", 2);

      nops(3);
      set_instr(0, 0, 3, 3, 8, 2, 0, 0);  issue("lw_issue3", 0);
      set_instr(0, 8, 3, 2, 0, 0, 0, 0);  issue("lw_sw_stalls", 0);
      nops(2);
      chk("lw_sw_fwd_rt_m", o_frtm, 1);

      nops(3);
      set_instr(0, 0, 3, 3, 0, 2, 0, 0);  issue("r0_write", 0);
      set_instr(0, 0, 1, 0, 5, 1, 0, 0);  issue("r0_read_stalls", 0);
      chk("r0_fwd_d", o_frsd + o_frtd, 0);
      nops(1);
      chk("r0_fwd_e", o_frse + o_frte, 0);

      nops(12);
      set_instr(0, 0, 3, 3, 0, 0, 0, 1);  issue("mult_issue", 0);
      set_instr(0, 0, 3, 3, 10, 1, 1, 0); issue("mult_mfhi_stalls", 1 + MC);
      nops(12);
      set_instr(0, 0, 3, 3, 0, 0, 0, 2);  issue("div_issue", 0);
      set_instr(0, 0, 3, 3, 10, 1, 1, 0); issue("div_mfhi_stalls", 1 + DC);

      nops(12);
      set_instr(0, 0, 3, 3, 0, 0, 0, 1);  issue("mult_issue2", 0);
      nops(3);
      do_reset();
      set_instr(0, 0, 3, 3, 10, 1, 1, 0); issue("mfhi_after_rst", 0);

      nops(12);
      set_instr(0, 0, 3, 3, 0, 0, 0, 2);  issue("div_issue2", 0);
      set_nop();
      EXC_FLUSH = 1'b1;
      run_cycle();
      EXC_FLUSH = 1'b0;
      chk("flush_busy_div_in_e", o_busy, 1);
      run_cycle();
      chk("flush_busy_after", o_busy, 0);
      set_instr(0, 0, 3, 3, 10, 1, 1, 0); issue("mfhi_after_flush", 0);

      nops(12);
      for (int i = 0; i < 1500; i++) begin
         if (e_stall == 0) begin
            int r;
            r = int'($urandom_range(0, 15));
            set_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                      ($urandom_range(0, 7) == 0) ? 1 : 0,
                      (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0);
         end
         EXC_FLUSH = ($urandom_range(0, 19) == 0);
         run_cycle();
         EXC_FLUSH = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
